// File: rtl/lsu_pkg.sv
// Shared encodings, state type and decode helpers for the load/store unit.
package lsu_pkg;

    localparam int BYTE_W = 8;

    // One-hot bit positions of ld_op (same assignment as the core's load encoding).
    localparam int LD_LD  = 0;
    localparam int LD_LW  = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LB  = 3;
    localparam int LD_LWU = 4;
    localparam int LD_LHU = 5;
    localparam int LD_LBU = 6;

    // One-hot bit positions of st_op.
    localparam int ST_SD = 0;
    localparam int ST_SW = 1;
    localparam int ST_SH = 2;
    localparam int ST_SB = 3;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'b00,
        EXC_LD_MISALIGN = 2'b01,
        EXC_ST_MISALIGN = 2'b10,
        EXC_ILLEGAL     = 2'b11
    } exc_code_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_EXC  = 3'd4
    } state_e;

    // log2 of the access size in bytes; assumes a one-hot op vector.
    function automatic logic [1:0] op_size_log2(input logic [6:0] ld_op, input logic [3:0] st_op);
        logic is_d;
        logic is_w;
        logic is_h;
        is_d = ld_op[LD_LD] | st_op[ST_SD];
        is_w = ld_op[LD_LW] | ld_op[LD_LWU] | st_op[ST_SW];
        is_h = ld_op[LD_LH] | ld_op[LD_LHU] | st_op[ST_SH];
        return {is_d | is_w, is_d | is_h};
    endfunction

    // Loads without the U suffix sign-extend.
    function automatic logic op_is_signed(input logic [6:0] ld_op);
        return ld_op[LD_LD] | ld_op[LD_LW] | ld_op[LD_LH] | ld_op[LD_LB];
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request, memory channel, writeback and exception signals of the LSU.
interface lsu_if #(
    parameter int XLEN = 64
);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic [6:0]      ld_op;
    logic [3:0]      st_op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] st_data;
    logic [4:0]      rd_idx;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [NB-1:0]   mem_wstrb;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rdata;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            exc_valid;
    logic [1:0]      exc_code;
    logic            busy;

    // The environment: execute stage, memory and writeback.
    modport master (
        output req_valid, ld_op, st_op, addr, st_data, rd_idx,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  wb_valid, wb_rd, wb_data, exc_valid, exc_code, busy
    );

    // The load/store unit itself.
    modport slave (
        input  req_valid, ld_op, st_op, addr, st_data, rd_idx,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output wb_valid, wb_rd, wb_data, exc_valid, exc_code, busy
    );
endinterface

// File: rtl/lsu_ext.sv
// Load extraction: align the addressed field to bit 0, then sign- or zero-extend it.
module lsu_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]            rdata,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [1:0]                 size_log2,
    input  logic                       sign_ext,
    output logic [XLEN-1:0]            data
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] raw;
    logic            msb;
    logic            fill;

    assign raw  = rdata >> {off, 3'b000};
    assign fill = sign_ext & msb;

    // Top bit of the accessed field, used as the extension bit.
    always_comb begin
        case (size_log2)
            2'd0:    msb = raw[7];
            2'd1:    msb = raw[15];
            2'd2:    msb = raw[31];
            default: msb = raw[XLEN-1];
        endcase
    end

    // Lanes inside the access keep their byte, lanes above it take the fill value.
    genvar gi;
    for (gi = 0; gi < NB; gi++) begin : g_lane
        localparam logic [3:0] LANE = 4'(gi);
        logic keep;
        assign keep = (LANE >> size_log2) == 4'd0;
        assign data[gi*BYTE_W +: BYTE_W] = keep ? raw[gi*BYTE_W +: BYTE_W] : {BYTE_W{fill}};
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store control: request decode, store lane steering, memory handshake, writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_e          state_reg, state_next;
    logic [6:0]      ld_op_reg, ld_op_next;
    logic [OFFW-1:0] off_reg, off_next;
    logic [4:0]      rd_reg, rd_next;
    logic            mem_req_valid_reg, mem_req_valid_next;
    logic [XLEN-1:0] mem_addr_reg, mem_addr_next;
    logic            mem_we_reg, mem_we_next;
    logic [NB-1:0]   mem_wstrb_reg, mem_wstrb_next;
    logic [XLEN-1:0] mem_wdata_reg, mem_wdata_next;
    logic            wb_valid_reg, wb_valid_next;
    logic [4:0]      wb_rd_reg, wb_rd_next;
    logic [XLEN-1:0] wb_data_reg, wb_data_next;
    logic            exc_valid_reg, exc_valid_next;
    logic [1:0]      exc_code_reg, exc_code_next;
    logic            busy_reg, busy_next;

    logic [1:0]      in_size_log2;
    logic [3:0]      in_bytes;
    logic [OFFW-1:0] in_off;
    logic [OFFW-1:0] in_align_mask;
    logic            in_is_store;
    logic            in_illegal;
    logic            in_misaligned;
    logic [8:0]      in_lane_mask;
    logic [NB-1:0]   in_strb;
    logic [XLEN-1:0] in_wdata;
    logic [XLEN-1:0] ld_data;

    // Classify the presented request and pre-compute its store lanes.
    always_comb begin
        in_size_log2  = op_size_log2(bus.ld_op, bus.st_op);
        in_bytes      = 4'd1 << in_size_log2;
        in_off        = bus.addr[OFFW-1:0];
        in_align_mask = OFFW'(in_bytes - 4'd1);
        in_is_store   = |bus.st_op;
        in_illegal    = !$onehot({bus.ld_op, bus.st_op})
                        || ((XLEN == 32) && (bus.ld_op[LD_LD] || bus.ld_op[LD_LWU] || bus.st_op[ST_SD]));
        in_misaligned = (in_off & in_align_mask) != '0;
        in_lane_mask  = (9'd1 << in_bytes) - 9'd1;
        in_strb       = in_lane_mask[NB-1:0] << in_off;
        in_wdata      = bus.st_data << {in_off, 3'b000};
    end

    lsu_ext #(.XLEN(XLEN)) u_ext (
        .rdata     (bus.mem_rdata),
        .off       (off_reg),
        .size_log2 (op_size_log2(ld_op_reg, 4'b0000)),
        .sign_ext  (op_is_signed(ld_op_reg)),
        .data      (ld_data)
    );

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_next         = state_reg;
        ld_op_next         = ld_op_reg;
        off_next           = off_reg;
        rd_next            = rd_reg;
        mem_req_valid_next = mem_req_valid_reg;
        mem_addr_next      = mem_addr_reg;
        mem_we_next        = mem_we_reg;
        mem_wstrb_next     = mem_wstrb_reg;
        mem_wdata_next     = mem_wdata_reg;
        wb_valid_next      = 1'b0;
        wb_rd_next         = wb_rd_reg;
        wb_data_next       = wb_data_reg;
        exc_valid_next     = 1'b0;
        exc_code_next      = exc_code_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid) begin
                    ld_op_next = bus.ld_op;
                    off_next   = in_off;
                    rd_next    = bus.rd_idx;
                    if (in_illegal) begin
                        exc_valid_next = 1'b1;
                        exc_code_next  = EXC_ILLEGAL;
                        state_next     = S_EXC;
                    end else if (in_misaligned) begin
                        exc_valid_next = 1'b1;
                        exc_code_next  = in_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        state_next     = S_EXC;
                    end else begin
                        // Request fields are captured once so they stay stable through stalls.
                        mem_req_valid_next = 1'b1;
                        mem_addr_next      = {bus.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        mem_we_next        = in_is_store;
                        mem_wstrb_next     = in_is_store ? in_strb : '0;
                        mem_wdata_next     = in_is_store ? in_wdata : '0;
                        state_next         = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_next = 1'b0;
                    state_next         = mem_we_reg ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    wb_valid_next = 1'b1;
                    wb_rd_next    = rd_reg;
                    wb_data_next  = ld_data;
                    state_next    = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            S_EXC:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers; reset clears everything and returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            ld_op_reg         <= '0;
            off_reg           <= '0;
            rd_reg            <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_addr_reg      <= '0;
            mem_we_reg        <= 1'b0;
            mem_wstrb_reg     <= '0;
            mem_wdata_reg     <= '0;
            wb_valid_reg      <= 1'b0;
            wb_rd_reg         <= '0;
            wb_data_reg       <= '0;
            exc_valid_reg     <= 1'b0;
            exc_code_reg      <= '0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            ld_op_reg         <= ld_op_next;
            off_reg           <= off_next;
            rd_reg            <= rd_next;
            mem_req_valid_reg <= mem_req_valid_next;
            mem_addr_reg      <= mem_addr_next;
            mem_we_reg        <= mem_we_next;
            mem_wstrb_reg     <= mem_wstrb_next;
            mem_wdata_reg     <= mem_wdata_next;
            wb_valid_reg      <= wb_valid_next;
            wb_rd_reg         <= wb_rd_next;
            wb_data_reg       <= wb_data_next;
            exc_valid_reg     <= exc_valid_next;
            exc_code_reg      <= exc_code_next;
            busy_reg          <= busy_next;
        end
    end

    assign bus.req_ready     = (state_reg == S_IDLE);
    assign bus.mem_req_valid = mem_req_valid_reg;
    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_we        = mem_we_reg;
    assign bus.mem_wstrb     = mem_wstrb_reg;
    assign bus.mem_wdata     = mem_wdata_reg;
    assign bus.wb_valid      = wb_valid_reg;
    assign bus.wb_rd         = wb_rd_reg;
    assign bus.wb_data       = wb_data_reg;
    assign bus.exc_valid     = exc_valid_reg;
    assign bus.exc_code      = exc_code_reg;
    assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a 64-bit and a 32-bit instance share one stimulus path selected by sel32.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel32 = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  ld_op = '0;
    logic [3:0]  st_op = '0;
    logic [63:0] addr = '0;
    logic [63:0] st_data = '0;
    logic [4:0]  rd_idx = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_if #(.XLEN(64)) bus64 ();
    lsu_if #(.XLEN(32)) bus32 ();

    lsu_ctrl #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    lsu_ctrl #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    assign bus64.req_valid     = req_valid && !sel32;
    assign bus64.ld_op         = ld_op;
    assign bus64.st_op         = st_op;
    assign bus64.addr          = addr;
    assign bus64.st_data       = st_data;
    assign bus64.rd_idx        = rd_idx;
    assign bus64.mem_req_ready = mem_req_ready;
    assign bus64.mem_rsp_valid = mem_rsp_valid;
    assign bus64.mem_rdata     = mem_rdata;
    assign bus32.req_valid     = req_valid && sel32;
    assign bus32.ld_op         = ld_op;
    assign bus32.st_op         = st_op;
    assign bus32.addr          = addr[31:0];
    assign bus32.st_data       = st_data[31:0];
    assign bus32.rd_idx        = rd_idx;
    assign bus32.mem_req_ready = mem_req_ready;
    assign bus32.mem_rsp_valid = mem_rsp_valid;
    assign bus32.mem_rdata     = mem_rdata[31:0];

    logic        o_req_ready, o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid, o_busy;
    logic [63:0] o_mem_addr, o_wdata, o_wb_data;
    logic [7:0]  o_wstrb;
    logic [4:0]  o_wb_rd;
    logic [1:0]  o_exc_code;

    always_comb begin
        o_req_ready     = sel32 ? bus32.req_ready     : bus64.req_ready;
        o_mem_req_valid = sel32 ? bus32.mem_req_valid : bus64.mem_req_valid;
        o_mem_we        = sel32 ? bus32.mem_we        : bus64.mem_we;
        o_wb_valid      = sel32 ? bus32.wb_valid      : bus64.wb_valid;
        o_exc_valid     = sel32 ? bus32.exc_valid     : bus64.exc_valid;
        o_busy          = sel32 ? bus32.busy          : bus64.busy;
        o_mem_addr      = sel32 ? {32'b0, bus32.mem_addr}  : bus64.mem_addr;
        o_wdata         = sel32 ? {32'b0, bus32.mem_wdata} : bus64.mem_wdata;
        o_wb_data       = sel32 ? {32'b0, bus32.wb_data}   : bus64.wb_data;
        o_wstrb         = sel32 ? {4'b0, bus32.mem_wstrb}  : bus64.mem_wstrb;
        o_wb_rd         = sel32 ? bus32.wb_rd    : bus64.wb_rd;
        o_exc_code      = sel32 ? bus32.exc_code : bus64.exc_code;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the op tables (0 when no op bit is set).
    function automatic int op_bytes(input logic [6:0] lop, input logic [3:0] sop);
        int b;
        b = 0;
        for (int i = 0; i < 7; i++)
            if (lop[i]) b = (i == 0) ? 8 : (i == 1 || i == 4) ? 4 : (i == 2 || i == 5) ? 2 : 1;
        for (int i = 0; i < 4; i++)
            if (sop[i]) b = (i == 0) ? 8 : (i == 1) ? 4 : (i == 2) ? 2 : 1;
        return b;
    endfunction

    // One complete transaction with its expected behaviour computed from the access rules.
    task automatic do_op(input bit w32, input logic [6:0] lop, input logic [3:0] sop,
                         input logic [63:0] a, input logic [63:0] sd, input logic [4:0] rd,
                         input logic [63:0] rdata, input int stall, input int dly);
        int          nb, sz, off;
        bit          sgn, ill, mis, is_st;
        logic [63:0] xmask, raw, fmask, exp_wb, exp_wdata, exp_addr;
        logic [7:0]  exp_strb;
        nb    = w32 ? 4 : 8;
        xmask = w32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        a     = a & xmask;
        sd    = sd & xmask;
        rdata = rdata & xmask;
        sz    = op_bytes(lop, sop);
        sgn   = (lop[0] || lop[1] || lop[2] || lop[3]);
        is_st = (sop != 4'b0);
        ill   = ($countones({lop, sop}) != 1) || (w32 && (lop[0] || lop[4] || sop[0]));
        mis   = !ill && ((a % 64'(sz)) != 64'd0);
        off   = int'(a % 64'(nb));
        exp_addr = a - 64'(off);

        sel32 = w32; req_valid = 1'b1; ld_op = lop; st_op = sop;
        addr = a; st_data = sd; rd_idx = rd;
        check("accept_ready", o_req_ready, 1'b1);
        step();
        // Scramble the request inputs: the unit must work from what it captured.
        req_valid = 1'b0; ld_op = 7'($urandom); st_op = 4'($urandom);
        addr = {$urandom, $urandom}; st_data = {$urandom, $urandom}; rd_idx = 5'($urandom);

        if (ill || mis) begin
            check("exc_valid", o_exc_valid, 1'b1);
            check("exc_code", o_exc_code, ill ? 2'b11 : (is_st ? 2'b10 : 2'b01));
            check("exc_no_req", o_mem_req_valid, 1'b0);
            check("exc_busy", o_busy, 1'b1);
            step();
            check("exc_pulse_end", o_exc_valid, 1'b0);
            check("exc_ready_again", o_req_ready, 1'b1);
            check("exc_no_req2", o_mem_req_valid, 1'b0);
            $display("txn w32=%0d ld=%b st=%b addr=%h -> exc %0d", w32, lop, sop, a, o_exc_code);
            return;
        end

        exp_strb  = is_st ? 8'(((1 << sz) - 1) << off) : 8'h00;
        exp_wdata = is_st ? ((sd << (8 * off)) & xmask) : 64'd0;
        for (int c = 0; c <= stall; c++) begin
            check("req_valid", o_mem_req_valid, 1'b1);
            check("req_addr", o_mem_addr, exp_addr);
            check("req_we", o_mem_we, is_st);
            check("req_wstrb", o_wstrb, exp_strb);
            check("req_wdata", o_wdata, exp_wdata);
            check("req_not_ready", o_req_ready, 1'b0);
            mem_req_ready = (c == stall);
            mem_rsp_valid = (c < stall) ? 1'($urandom) : 1'b0;
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("req_dropped", o_mem_req_valid, 1'b0);

        if (is_st) begin
            check("st_idle", o_req_ready, 1'b1);
            check("st_no_wb", o_wb_valid, 1'b0);
            $display("txn w32=%0d st=%b addr=%h strb=%h wdata=%h", w32, sop, a, o_wstrb, o_wdata);
            return;
        end

        for (int c = 0; c < dly; c++) begin
            check("wait_no_wb", o_wb_valid, 1'b0);
            check("wait_busy", o_busy, 1'b1);
            mem_req_ready = 1'($urandom);
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = rdata;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata = {$urandom, $urandom};

        raw   = rdata >> (8 * off);
        fmask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        exp_wb = raw & fmask;
        if (sgn && raw[8 * sz - 1]) exp_wb = exp_wb | ~fmask;
        exp_wb = exp_wb & xmask;
        check("wb_valid", o_wb_valid, 1'b1);
        check("wb_data", o_wb_data, exp_wb);
        check("wb_rd", o_wb_rd, rd);
        check("wb_not_ready", o_req_ready, 1'b0);
        step();
        check("wb_pulse_end", o_wb_valid, 1'b0);
        check("wb_ready_again", o_req_ready, 1'b1);
        check("wb_data_hold", o_wb_data, exp_wb);
        $display("txn w32=%0d ld=%b addr=%h rdata=%h -> wb_data=%h", w32, lop, a, rdata, o_wb_data);
    endtask

    task automatic rand_op(input bit w32);
        int          r, sz;
        logic [6:0]  lop;
        logic [3:0]  sop;
        logic [63:0] a;
        r = $urandom_range(0, 11);
        lop = '0;
        sop = '0;
        if (r < 7) lop = 7'(1 << r);
        else if (r < 11) sop = 4'(1 << (r - 7));
        else begin
            lop = 7'($urandom);
            sop = 4'($urandom);
        end
        a = {$urandom, $urandom};
        sz = op_bytes(lop, sop);
        if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % 64'(sz));
        do_op(w32, lop, sop, a, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check("rst_ready", o_req_ready, 1'b1);
        check("rst_ctrl", {o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid, o_busy, o_exc_code, o_wb_rd, o_wstrb}, 64'd0);
        check("rst_data", o_mem_addr | o_wdata | o_wb_data, 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_ready", o_req_ready, 1'b1);

        // Directed cases
        do_op(1'b0, 7'b0001000, 4'b0000, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0);
        check("lb_data", o_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_rd", o_wb_rd, 5'd7);
        do_op(1'b0, 7'b0100000, 4'b0000, 64'h2006, 64'h0, 5'd12, 64'hBEEF_0000_0000_0000, 1, 2);
        check("lhu_data", o_wb_data, 64'h0000_0000_0000_BEEF);
        do_op(1'b0, 7'b0000000, 4'b0100, 64'h100A, 64'h1234, 5'd3, 64'h0, 3, 0);
        check("sh_strb", o_wstrb, 8'h0C);
        check("sh_addr", o_mem_addr, 64'h1008);
        check("sh_wdata", o_wdata, 64'h0000_0000_1234_0000);
        do_op(1'b0, 7'b0000010, 4'b0000, 64'h1002, 64'h0, 5'd1, 64'h0, 0, 0);
        check("lw_mis_code", o_exc_code, 2'b01);
        do_op(1'b0, 7'b0000001, 4'b0001, 64'h1000, 64'h0, 5'd1, 64'h0, 0, 0);
        check("both_ops_code", o_exc_code, 2'b11);
        do_op(1'b1, 7'b0000000, 4'b0001, 64'h10, 64'h55, 5'd2, 64'h0, 0, 0);
        check("x32_sd_code", o_exc_code, 2'b11);
        do_op(1'b1, 7'b0010000, 4'b0000, 64'h10, 64'h0, 5'd2, 64'h0, 0, 0);
        check("x32_lwu_code", o_exc_code, 2'b11);
        do_op(1'b1, 7'b0000010, 4'b0000, 64'h4, 64'h0, 5'd9, 64'h8000_0001, 0, 0);
        check("x32_lw_data", o_wb_data, 64'h8000_0001);

        // Randomized traffic on both widths
        for (int t = 0; t < 40; t++) rand_op(1'b0);
        for (int t = 0; t < 20; t++) rand_op(1'b1);
        sel32 = 1'b0;

        // Reset while waiting for a load response; the late response must be ignored
        req_valid = 1'b1; ld_op = 7'b0000010; st_op = 4'b0000; addr = 64'h3000; rd_idx = 5'd4;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rstwait_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstwait_ready", o_req_ready, 1'b1);
        check("rstwait_ctrl", {o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid, o_busy, o_exc_code, o_wb_rd, o_wstrb}, 64'd0);
        check("rstwait_data", o_mem_addr | o_wdata | o_wb_data, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        mem_rsp_valid = 1'b0;
        check("stale_rsp_wb", o_wb_valid, 1'b0);
        check("stale_rsp_idle", o_busy, 1'b0);
        step();
        check("stale_rsp_wb2", o_wb_valid, 1'b0);
        check("stale_rsp_data", o_wb_data, 64'd0);
        $display("txn reset during WAIT, stale response ignored: wb_valid=%0d", o_wb_valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
